tdpram_sclk_be: RTL and testbench
=================================

# tdpram_sclk_be

Parametrised single-clock true dual-port RAM, successor to the fixed 8-bit × 64-word dual-port RAM. It adds:
- configurable data width and depth,
- per-port byte enables and port enables,
- a selectable read-during-write mode,
- deterministic write-collision resolution with a collision flag,
- a post-reset memory-clear sequencer.

It serves as the shared scratch/buffer memory between two masters in the same clock domain.

## Interface
- `DATA_W`, 8, word width in bits; must be a multiple of `BYTE_W`
- `BYTE_W`, 8, byte-lane width; `NB = DATA_W/BYTE_W` lanes
- `ADDR_W`, 6, address width; `DEPTH = 2**ADDR_W` words
- `RDW_MODE`, 0, same-port read-during-write: 0 = new data (write-through), 1 = old data
- `CLEAR_ON_RESET`, 1, 1 = zero all words after reset, 0 = skip the clear (contents undefined)
- `clk` input 1: single clock, all logic on its rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `en_a`, `en_b` input 1: port enable; when low, the port neither reads nor writes and `q` holds
- `we_a`, `we_b` input 1: write enable, qualified by `en`
- `be_a`, `be_b` input NB: byte-lane write enables, qualified by `we`
- `addr_a`, `addr_b` input ADDR_W: word address
- `data_a`, `data_b` input DATA_W: write data
- `q_a`, `q_b` output DATA_W: read data
- `init_busy` output 1: clear sequence in progress
- `collision` output 1: one-cycle pulse, same-address conflict occurred

## Operation
- Reset state of outputs: `q_a` = `q_b` = 0, `collision` = 0, and `init_busy` = `CLEAR_ON_RESET`.
- Clear FSM states:
  - CLEAR: a counter `clr_addr` runs from 0 to DEPTH-1 and writes zero to one word per cycle.
  - READY: normal operation.
- Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise READY.
- CLEAR moves to READY in the cycle after `clr_addr` = DEPTH-1 is written. The counter does not wrap.
- During CLEAR, port enables are ignored: writes are dropped, `q` holds 0, and `collision` stays 0.
- Write: when `en` & `we`, each lane i with `be[i]`=1 is written with `data[i*BYTE_W +: BYTE_W]`. Lanes with `be[i]`=0 are untouched. `we`=1 with `be`=0 is a read.
- Read: when `en` is high, `q` loads the word at `addr`.
- Same-port read-during-write:
  - `RDW_MODE`=0: `q` shows the merged new word (old bytes where `be`=0).
  - `RDW_MODE`=1: `q` shows the pre-write word.
- Cross-port read: a read on one port of an address the other port writes in the same cycle returns the old word.
- Collision: both ports enabled, `addr_a` == `addr_b`, and at least one port writing.
  - Both writing: lanes enabled on A take A's data. Lanes enabled only on B take B's data. Port A has priority.
  - `collision` pulses high in the following cycle.
  - Both ports reading the same address is not a collision.
- The address space is fully decoded, so there are no out-of-range addresses.

## Timing
- Read latency is 1 cycle (addr/en sampled at edge N, `q` valid after edge N). Write data is visible to a port-A or port-B read issued at edge N+1.
- `collision` asserts one cycle after the conflicting edge and lasts exactly one cycle per conflicting edge. Back-to-back conflicts keep it high.
- `init_busy` is high from reset release for exactly DEPTH cycles, then low.
- Asynchronous assertion of `rst_n` at any point, including mid-CLEAR:
  - outputs return to reset values immediately;
  - the clear restarts from address 0 after release.
- Memory contents are not reset asynchronously; only the CLEAR sequence zeroes them.

## Configuration
- `TDPRAM_OUTREG_EN` adds an output register stage on `q_a`/`q_b` (reset 0).
  - Read latency becomes 2 cycles.
  - The stage's enable follows the port `en` delayed by one cycle.
  - `collision` is also delayed one extra cycle, so it stays aligned with the affected `q`.
- Without the macro, latency is 1 as specified above.

## Structure
- A shared package `tdpram_pkg` holds the clear-FSM state enum (`CLEAR`, `READY`), the `RDW_NEW`/`RDW_OLD` constants, and the function computing NB.
- Sub-module `tdpram_clear_seq` contains the FSM, `clr_addr`, and `init_busy`, and drives a write-override interface into the port-A write path.
- The top level holds the memory array, byte-lane merge, collision logic, and output registers.

## Test plan
1. Clear: release reset with `CLEAR_ON_RESET`=1 and `ADDR_W`=6. Expect `init_busy` high for exactly 64 cycles; after that, reads of addr 0 and addr 63 return 0.
2. Basic R/W: A writes 0xAA to addr 0 and B writes 0xBB to addr 1, then A reads addr 1 and B reads addr 0. Expect `q_a`=0xBB and `q_b`=0xAA one cycle after the reads, and `collision`=0.
3. Byte enables: `DATA_W`=32, addr 5 holds 0x11223344. A writes 0xAABBCCDD with `be`=0101. A read then returns 0x11BB33DD.
4. Collision: `DATA_W`=16, addr 3, A writes 0xAAAA with `be`=01, B writes 0xBBBB with `be`=11. Memory then holds 0xBBAA, and `collision` is a 1-cycle pulse on the next cycle.
5. RDW modes: addr 7 holds 0x55, A writes 0x66 with a same-port read. Expect `q_a`=0x66 with `RDW_MODE`=0 and 0x55 with `RDW_MODE`=1. B reading addr 7 in the same cycle gets 0x55 in both modes.
6. Reset mid-clear: assert `rst_n` at clear cycle 20. Expect `q` = 0 immediately, and after release `init_busy` high for the full 64 cycles. With `TDPRAM_OUTREG_EN`, repeat case 2 and expect 2-cycle latency.

Source files
------------

// File: rtl/tdpram_pkg.sv
// Shared types and helpers for the single-clock true dual-port RAM.
package tdpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int RDW_NEW = 0;
  localparam int RDW_OLD = 1;

  function automatic int calc_nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/tdpram_clear_seq.sv
// Post-reset clear sequencer: zeroes one word per cycle through the port-A write path.
// init_busy is high for exactly 2**ADDR_W cycles after reset release; no backpressure.
module tdpram_clear_seq
  import tdpram_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam clr_state_e        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  clr_state_e state;

  // The counter parks on the last address instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      clr_addr  <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else if (state == CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state     <= READY;
        init_busy <= 1'b0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

  assign clr_we = (state == CLEAR);

endmodule

// File: rtl/tdpram_sclk_be.sv
// Single-clock true dual-port RAM with byte enables, port-A-priority collisions and clear-on-reset.
// Read latency 1 (2 with TDPRAM_OUTREG_EN); no backpressure, ports are always accepted.
module tdpram_sclk_be
  import tdpram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = 6,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = calc_nb(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              en_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [NB-1:0]     be_a,
  input  logic [NB-1:0]     be_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic              init_busy,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  tdpram_clear_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_busy(init_busy)
  );

  logic              act_a, act_b, wr_a, wr_b, coll_now;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data, old_a, old_b, new_a, new_b, base_w, word_w;
  logic [NB-1:0]     wa_be;

  always_comb begin
    act_a   = en_a & ~clr_we;
    act_b   = en_b & ~clr_we;
    wr_a    = clr_we | (act_a & we_a);
    wr_b    = act_b & we_b;
    wa_addr = clr_we ? clr_addr : addr_a;
    wa_data = clr_we ? '0 : data_a;
    wa_be   = clr_we ? '1 : be_a;
    old_a   = mem[addr_a];
    old_b   = mem[addr_b];
    new_a   = old_a;
    new_b   = old_b;
    for (int i = 0; i < NB; i++) begin
      if (be_a[i]) new_a[i*BYTE_W +: BYTE_W] = data_a[i*BYTE_W +: BYTE_W];
      if (be_b[i]) new_b[i*BYTE_W +: BYTE_W] = data_b[i*BYTE_W +: BYTE_W];
    end
    // Port A merges on top of B's result so B keeps only the lanes A leaves alone.
    base_w = (wr_b && (addr_b == wa_addr)) ? new_b : mem[wa_addr];
    word_w = base_w;
    for (int i = 0; i < NB; i++) begin
      if (wa_be[i]) word_w[i*BYTE_W +: BYTE_W] = wa_data[i*BYTE_W +: BYTE_W];
    end
    coll_now = act_a & act_b & (addr_a == addr_b) &
               ((we_a & (|be_a)) | (we_b & (|be_b)));
  end

  // Port A is written last so it wins the shared address.
  always_ff @(posedge clk) begin
    if (wr_b) mem[addr_b] <= new_b;
    if (wr_a) mem[wa_addr] <= word_w;
  end

  logic [DATA_W-1:0] q_a_r, q_b_r;
  logic              coll_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_r  <= '0;
      q_b_r  <= '0;
      coll_r <= 1'b0;
    end else if (clr_we) begin
      q_a_r  <= '0;
      q_b_r  <= '0;
      coll_r <= 1'b0;
    end else begin
      if (en_a) q_a_r <= (we_a && (RDW_MODE == RDW_NEW)) ? new_a : old_a;
      if (en_b) q_b_r <= (we_b && (RDW_MODE == RDW_NEW)) ? new_b : old_b;
      coll_r <= coll_now;
    end
  end

`ifdef TDPRAM_OUTREG_EN
  logic en_a_d, en_b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_a_d    <= 1'b0;
      en_b_d    <= 1'b0;
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else begin
      en_a_d    <= act_a;
      en_b_d    <= act_b;
      collision <= coll_r;
      if (en_a_d) q_a <= q_a_r;
      if (en_b_d) q_b <= q_b_r;
    end
  end
`else
  assign q_a       = q_a_r;
  assign q_b       = q_b_r;
  assign collision = coll_r;
`endif

endmodule

// File: tb/tb_tdpram_sclk_be.sv
// Directed bench for tdpram_sclk_be: two instances (new-data and old-data read-during-write)
// share stimulus and are compared every cycle against a word-level behavioural model.
module tb_tdpram_sclk_be;

  localparam int DEPTH = 64;
`ifdef TDPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [3:0]  be_a = '0, be_b = '0;
  logic [5:0]  addr_a = '0, addr_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;
  logic        busy0, busy1, coll0, coll1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  tdpram_sclk_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .be_a(be_a), .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q_a0), .q_b(q_b0), .init_busy(busy0), .collision(coll0));

  tdpram_sclk_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .be_a(be_a), .be_b(be_b), .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q_a1), .q_b(q_b1), .init_busy(busy1), .collision(coll1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [DEPTH];
  int          clr_cnt = 0;
  logic [31:0] s_qa [2] = '{32'h0, 32'h0};
  logic [31:0] s_qb [2] = '{32'h0, 32'h0};
  logic [31:0] e_qa [2] = '{32'h0, 32'h0};
  logic [31:0] e_qb [2] = '{32'h0, 32'h0};
  logic        s_coll = 1'b0, e_coll = 1'b0, e_busy = 1'b1;
  logic        s_ena = 1'b0, s_enb = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] n_qa [2];
    logic [31:0] n_qb [2];
    logic [31:0] oa, ob;
    logic        n_coll, busy_now;
    if (!rst_n) begin
      clr_cnt = 0;
      s_qa = '{32'h0, 32'h0}; s_qb = '{32'h0, 32'h0};
      e_qa = '{32'h0, 32'h0}; e_qb = '{32'h0, 32'h0};
      s_coll = 1'b0; e_coll = 1'b0; s_ena = 1'b0; s_enb = 1'b0;
      e_busy = 1'b1;
    end else begin
      busy_now = (clr_cnt < DEPTH);
      n_qa = s_qa; n_qb = s_qb; n_coll = 1'b0;
      if (busy_now) begin
        clr_cnt++;
        if (clr_cnt == DEPTH) for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        n_qa = '{32'h0, 32'h0}; n_qb = '{32'h0, 32'h0};
      end else begin
        oa = mm[addr_a];
        ob = mm[addr_b];
        if (en_a) begin
          n_qa[0] = we_a ? merge(oa, data_a, be_a) : oa;
          n_qa[1] = oa;
        end
        if (en_b) begin
          n_qb[0] = we_b ? merge(ob, data_b, be_b) : ob;
          n_qb[1] = ob;
        end
        n_coll = en_a && en_b && (addr_a == addr_b) &&
                 ((we_a && be_a != 0) || (we_b && be_b != 0));
        if (en_b && we_b) mm[addr_b] = merge(mm[addr_b], data_b, be_b);
        if (en_a && we_a) mm[addr_a] = merge(mm[addr_a], data_a, be_a);
      end
`ifdef TDPRAM_OUTREG_EN
      if (s_ena) e_qa = s_qa;
      if (s_enb) e_qb = s_qb;
      e_coll = s_coll;
      s_ena = en_a && !busy_now;
      s_enb = en_b && !busy_now;
`endif
      s_qa = n_qa; s_qb = n_qb; s_coll = n_coll;
`ifndef TDPRAM_OUTREG_EN
      e_qa = s_qa; e_qb = s_qb; e_coll = s_coll;
`endif
      e_busy = (clr_cnt < DEPTH);
    end
  end

  always @(negedge clk) begin
    check("q_a new-mode", q_a0, e_qa[0]);
    check("q_b new-mode", q_b0, e_qb[0]);
    check("q_a old-mode", q_a1, e_qa[1]);
    check("q_b old-mode", q_b1, e_qb[1]);
    check("collision new-mode", {31'b0, coll0}, {31'b0, e_coll});
    check("collision old-mode", {31'b0, coll1}, {31'b0, e_coll});
    check("init_busy", {31'b0, busy0}, {31'b0, e_busy});
    check("init_busy old-mode", {31'b0, busy1}, {31'b0, e_busy});
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic ea, input logic wa, input logic [3:0] ba, input logic [5:0] aa,
                    input logic [31:0] da, input logic eb, input logic wb, input logic [3:0] bb,
                    input logic [5:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_b = db;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    while (busy0 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, cnt, 64);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: clear lasts 64 cycles, memory ends at zero
    count_busy("clear busy cycles");
    op(1, 0, 4'h0, 6'd0, 32'h0, 1, 0, 4'h0, 6'd63, 32'h0);
    idle(LAT - 1);
    check("read addr0 after clear", q_a0, 32'h0);
    check("read addr63 after clear", q_b0, 32'h0);

    // 2: basic cross-port write then read
    op(1, 1, 4'hf, 6'd0, 32'h0000_00AA, 1, 1, 4'hf, 6'd1, 32'h0000_00BB);
    op(1, 0, 4'h0, 6'd1, 32'h0, 1, 0, 4'h0, 6'd0, 32'h0);
    idle(LAT - 1);
    check("basic q_a", q_a0, 32'h0000_00BB);
    check("basic q_b", q_b0, 32'h0000_00AA);
    check("basic collision", {31'b0, coll0}, 32'h0);

    // 3: byte enables
    op(1, 1, 4'hf, 6'd5, 32'h1122_3344, 0, 0, 4'h0, 6'd0, 32'h0);
    op(1, 1, 4'h5, 6'd5, 32'hAABB_CCDD, 0, 0, 4'h0, 6'd0, 32'h0);
    op(1, 0, 4'h0, 6'd5, 32'h0, 0, 0, 4'h0, 6'd0, 32'h0);
    idle(LAT - 1);
    check("byte-enable merge", q_a0, 32'h11BB_33DD);

    // 4: write collision, A wins lane 0, B keeps lane 1
    op(1, 1, 4'h1, 6'd3, 32'h0000_AAAA, 1, 1, 4'h3, 6'd3, 32'h0000_BBBB);
    idle(LAT - 1);
    check("collision pulse", {31'b0, coll0}, 32'h1);
    idle(1);
    check("collision single cycle", {31'b0, coll0}, 32'h0);
    check("model collision word", mm[3], 32'h0000_BBAA);
    op(0, 0, 4'h0, 6'd0, 32'h0, 1, 0, 4'h0, 6'd3, 32'h0);
    idle(LAT - 1);
    check("collision word", q_b0, 32'h0000_BBAA);

    // 5: read-during-write modes
    op(1, 1, 4'hf, 6'd7, 32'h0000_0055, 0, 0, 4'h0, 6'd0, 32'h0);
    op(1, 1, 4'hf, 6'd7, 32'h0000_0066, 1, 0, 4'h0, 6'd7, 32'h0);
    idle(LAT - 1);
    check("rdw new-data q_a", q_a0, 32'h0000_0066);
    check("rdw old-data q_a", q_a1, 32'h0000_0055);
    check("rdw cross q_b new-mode", q_b0, 32'h0000_0055);
    check("rdw cross q_b old-mode", q_b1, 32'h0000_0055);
    check("model rdw word", mm[7], 32'h0000_0066);

    // 6: async reset while running and mid-clear
    rst_n = 1'b0;
    #1;
    check("reset q_a immediate", q_a0, 32'h0);
    check("reset busy immediate", {31'b0, busy0}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid-clear reset q_b", q_b0, 32'h0);
    check("mid-clear reset collision", {31'b0, coll0}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    count_busy("restarted clear busy cycles");
    op(1, 0, 4'h0, 6'd5, 32'h0, 1, 0, 4'h0, 6'd7, 32'h0);
    idle(LAT - 1);
    check("addr5 cleared", q_a0, 32'h0);
    check("addr7 cleared", q_b0, 32'h0);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
